// File: rtl/lut4_cfg_loader.sv
// Configuration sequencer for a 4-input LUT: collects a 16-bit truth table serially,
// writes it bit by bit through the level-sensitive config port, then optionally reads it back.
module lut4_cfg_loader #(
  parameter int HOLD_CYCLES = 2,
  parameter bit VERIFY_EN   = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_bit,
  input  logic       i_bit_valid,
  output logic       o_bit_ready,
  output logic [3:0] o_cfg_addr,
  output logic       o_cfg_data,
  output logic       o_cfg_enable,
  output logic [3:0] o_lut_sel,
  input  logic       i_lut_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_SETUP, S_PULSE, S_RELEASE, S_VDRIVE, S_VCMP, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]    addr_q, addr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          bit_ready_q, bit_ready_d;
  logic [3:0]    cfg_addr_q, cfg_addr_d;
  logic          cfg_data_q, cfg_data_d;
  logic          cfg_en_q, cfg_en_d;
  logic [3:0]    lut_sel_q, lut_sel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    bit_cnt_d  = bit_cnt_q;
    addr_d     = addr_q;
    hold_d     = hold_q;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    lut_sel_d  = lut_sel_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_COLLECT;
          bit_cnt_d = 4'd0;
          error_d   = 1'b0;
        end
      end
      S_COLLECT: begin
        // MSB-first: shifting left leaves the first accepted bit in shadow[15]
        if (i_bit_valid && bit_ready_q) begin
          shadow_d  = {shadow_q[14:0], i_bit};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            state_d = S_SETUP;
            addr_d  = 4'd0;
          end
        end
      end
      S_SETUP: begin
        state_d = S_PULSE;
        hold_d  = '0;
      end
      S_PULSE: begin
        if (hold_q == HW'(HOLD_CYCLES - 1)) state_d = S_RELEASE;
        else                                hold_d  = hold_q + 1'b1;
      end
      S_RELEASE: begin
        if (addr_q == 4'd15) begin
          addr_d  = 4'd0;
          state_d = VERIFY_EN ? S_VDRIVE : S_DONE;
        end else begin
          addr_d  = addr_q + 4'd1;
          state_d = S_SETUP;
        end
      end
      S_VDRIVE: state_d = S_VCMP;
      S_VCMP: begin
        if (i_lut_data != shadow_q[addr_q]) error_d = 1'b1;
        if (addr_q == 4'd15) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 4'd1;
          state_d = S_VDRIVE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the state once registered
    bit_ready_d = (state_d == S_COLLECT);
    cfg_en_d    = (state_d == S_PULSE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    if (state_d == S_SETUP) begin
      cfg_addr_d = addr_d;
      cfg_data_d = shadow_d[addr_d];
    end
    if (state_d == S_VDRIVE) lut_sel_d = addr_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      bit_cnt_q   <= '0;
      addr_q      <= '0;
      hold_q      <= '0;
      bit_ready_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= 1'b0;
      cfg_en_q    <= 1'b0;
      lut_sel_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      bit_ready_q <= bit_ready_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      cfg_en_q    <= cfg_en_d;
      lut_sel_q   <= lut_sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign o_bit_ready  = bit_ready_q;
  assign o_cfg_addr   = cfg_addr_q;
  assign o_cfg_data   = cfg_data_q;
  assign o_cfg_enable = cfg_en_q;
  assign o_lut_sel    = lut_sel_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_lut4_cfg_loader.sv
// Scoreboard bench: a verifying loader with a behavioural LUT, plus a non-verifying
// loader sharing the same stimulus to cover the shorter write-only sequence.
module tb_lut4_cfg_loader;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1, i_start = 1'b0, i_bit = 1'b0, i_bit_valid = 1'b0;
  logic       bit_ready0, cfg_data0, cfg_en0, lut_data0, busy0, done0, error0;
  logic [3:0] cfg_addr0, lut_sel0;
  logic       bit_ready1, cfg_data1, cfg_en1, busy1, done1, error1;
  logic [3:0] cfg_addr1, lut_sel1;

  int errors = 0, checks = 0, cyc = 0;

  typedef struct { int cyc; logic err; logic [15:0] tbl; } exp_t;
  exp_t q0[$];
  int   q1[$];

  logic [15:0] lut_mem = 16'h0;
  bit          stuck3 = 1'b0;

  lut4_cfg_loader #(.HOLD_CYCLES(2), .VERIFY_EN(1'b1)) dut0 (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_bit(i_bit), .i_bit_valid(i_bit_valid),
    .o_bit_ready(bit_ready0), .o_cfg_addr(cfg_addr0), .o_cfg_data(cfg_data0), .o_cfg_enable(cfg_en0),
    .o_lut_sel(lut_sel0), .i_lut_data(lut_data0), .o_busy(busy0), .o_done(done0), .o_error(error0));

  lut4_cfg_loader #(.HOLD_CYCLES(2), .VERIFY_EN(1'b0)) dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_bit(i_bit), .i_bit_valid(i_bit_valid),
    .o_bit_ready(bit_ready1), .o_cfg_addr(cfg_addr1), .o_cfg_data(cfg_data1), .o_cfg_enable(cfg_en1),
    .o_lut_sel(lut_sel1), .i_lut_data(1'b0), .o_busy(busy1), .o_done(done1), .o_error(error1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural LUT: contents survive reset; optional stuck-at-0 on config bit 3
  always @(posedge clk) if (cfg_en0) lut_mem[cfg_addr0] <= (stuck3 && cfg_addr0 == 4'd3) ? 1'b0 : cfg_data0;
  assign lut_data0 = lut_mem[lut_sel0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the verifying loader: pulse shape bookkeeping and done-time comparison
  int en_cyc = 0, en_rise = 0, unstable = 0;
  logic prev_en = 1'b0, prev_data = 1'b0;
  logic [3:0] prev_addr = 4'd0;
  always @(negedge clk) begin
    if (i_rst) begin
      en_cyc = 0; en_rise = 0; unstable = 0; prev_en = 1'b0;
    end else begin
      if (cfg_en0) begin
        en_cyc++;
        if (!prev_en) en_rise++;
        else if (cfg_addr0 != prev_addr || cfg_data0 != prev_data) unstable++;
      end
      prev_en = cfg_en0; prev_addr = cfg_addr0; prev_data = cfg_data0;
      if (done0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done0: got done at cycle %0d expected none", cyc);
        end else begin
          exp_t e;
          e = q0.pop_front();
          chk("done0_cycle", cyc, e.cyc);
          chk("done0_error", {31'd0, error0}, {31'd0, e.err});
          chk("lut_table", {16'd0, lut_mem}, {16'd0, e.tbl});
          chk("enable_cycles", en_cyc, 32);
          chk("enable_pulses", en_rise, 16);
          chk("addr_data_stable", unstable, 0);
        end
        en_cyc = 0; en_rise = 0; unstable = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!i_rst && done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done1: got done at cycle %0d expected none", cyc);
      end else begin
        chk("done1_cycle", cyc, q1.pop_front());
        chk("done1_lut_sel", {28'd0, lut_sel1}, 32'd0);
        chk("done1_error", {31'd0, error1}, 32'd0);
      end
    end
  end

  task automatic send_word(input logic [15:0] w, input bit toggle, input bit mid_start,
                           input bit push, input logic [15:0] tbl, input logic err);
    int idx = 15;
    int guard = 0;
    bit ph = 1'b0;
    bit rdy;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    chk("start_clears_error", {31'd0, error0}, 32'd0);
    chk("start_busy", {31'd0, busy0}, 32'd1);
    while (idx >= 0 && guard < 200) begin
      rdy = bit_ready0;
      i_bit_valid = toggle ? ph : 1'b1;
      ph = !ph;
      i_bit = w[idx];
      i_start = mid_start && (idx == 8);
      @(negedge clk);
      if (i_bit_valid && rdy) idx--;
      guard++;
    end
    i_bit_valid = 1'b0; i_start = 1'b0;
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL collect_timeout: accepted %0d bits expected 16", 15 - idx);
    end
    // cyc here marks cycle 1 after the 16th-bit accept edge
    if (push) begin
      q0.push_back('{cyc: cyc + 96, err: err, tbl: tbl});
      q1.push_back(cyc + 64);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL done_timeout: pending %0d expected 0", q0.size() + q1.size());
      q0.delete(); q1.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bit_ready0, cfg_addr0, cfg_data0, cfg_en0, lut_sel0, busy0, done0, error0}, 32'd0);
    i_rst = 1'b0;

    // single one at the top address
    send_word(16'h8000, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0);
    wait_done();

    // valid toggling: only handshaken bits land
    send_word(16'hA5C3, 1'b1, 1'b0, 1'b1, 16'hA5C3, 1'b0);
    wait_done();

    // stuck config bit 3 must be caught by readback and stay sticky
    stuck3 = 1'b1;
    send_word(16'hFFFF, 1'b0, 1'b0, 1'b1, 16'hFFF7, 1'b1);
    wait_done();
    stuck3 = 1'b0;
    repeat (3) @(negedge clk);
    chk("error_sticky_idle", {30'd0, error0, busy0}, 32'd2);

    // reset during the enable pulse of address 7 (start also clears the sticky error)
    send_word(16'h5A5A, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    begin
      int n = 0;
      while (!(cfg_en0 && cfg_addr0 == 4'd7) && n < 200) begin @(negedge clk); n++; end
      chk("reach_addr7_pulse", {31'd0, cfg_en0}, 32'd1);
    end
    i_rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset_outputs", {bit_ready0, cfg_addr0, cfg_data0, cfg_en0, lut_sel0, busy0, done0, error0}, 32'd0);
    chk("midrun_reset_dut1", {bit_ready1, cfg_addr1, cfg_data1, cfg_en1, busy1, done1}, 32'd0);
    i_rst = 1'b0;
    send_word(16'h0001, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);
    wait_done();

    // start pulse during collection is ignored
    send_word(16'h1234, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0);
    wait_done();

    // reset wins over start on the same edge
    i_start = 1'b1; i_rst = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_rst = 1'b0;
    chk("rst_start_busy", {30'd0, busy0, bit_ready0}, 32'd0);
    @(negedge clk);
    chk("rst_start_stays_idle", {30'd0, busy0, busy1}, 32'd0);

    chk("scoreboard_empty", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lut4_cfg_loader.md
Name: lut4_cfg_loader

Overview:
- Configuration sequencer for the 4-input LUT cell.
- Takes a 16-bit truth table as a serial bit stream over a valid/ready handshake and stores it in a shadow register.
- Drives the LUT's level-sensitive config port (address, data, enable) one bit at a time, with explicit setup, pulse and release phases.
- Optionally reads the table back through the LUT select inputs and flags any mismatch.

Parameters:
- HOLD_CYCLES, 2, number of cycles o_cfg_enable stays high per written bit (≥1).
- VERIFY_EN, 1, when 1 a readback sweep runs after writing; when 0 it is skipped.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- i_bit  input  1  serial truth-table bit.
- i_bit_valid  input  1  i_bit is valid this cycle.
- o_bit_ready  output  1  loader accepts a bit this cycle.
- o_cfg_addr  output  4  LUT config address.
- o_cfg_data  output  1  LUT config data.
- o_cfg_enable  output  1  LUT config enable (level-sensitive write).
- o_lut_sel  output  4  LUT select inputs, driven during readback.
- i_lut_data  input  1  LUT output; combinational from o_lut_sel.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse at the end of a load.
- o_error  output  1  sticky readback mismatch flag.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0; state = IDLE; shadow = 0; counters = 0.
- Reset has priority over every other input, including i_start on the same edge.
- Reset mid-operation:
  - Every output returns to 0 on the reset edge.
  - The partially written LUT contents are left as they are.
- IDLE:
  - o_bit_ready = 0; i_bit_valid is ignored.
  - i_start → COLLECT; bit count cleared; o_error cleared.
- COLLECT:
  - o_bit_ready = 1.
  - A bit is accepted on each edge where i_bit_valid & o_bit_ready.
  - Bits arrive MSB-first: the first accepted bit is shadow[15], the 16th is shadow[0].
  - The edge that accepts the 16th bit moves to WRITE with address 0. o_bit_ready drops the following cycle.
  - i_start is ignored in every non-IDLE state.
- WRITE: each address k = 0..15 occupies 2+HOLD_CYCLES cycles.
  - SETUP, 1 cycle: o_cfg_addr = k, o_cfg_data = shadow[k], o_cfg_enable = 0.
  - PULSE, HOLD_CYCLES cycles: same address and data, o_cfg_enable = 1.
  - RELEASE, 1 cycle: same address and data, o_cfg_enable = 0.
  - o_cfg_addr and o_cfg_data never change while o_cfg_enable = 1.
  - o_cfg_addr wraps only by exiting the state: after the RELEASE of address 15, go to VERIFY if VERIFY_EN = 1, else to DONE.
- VERIFY: o_cfg_enable = 0 throughout; each address k = 0..15 occupies 2 cycles.
  - Drive cycle: o_lut_sel = k.
  - Compare cycle: o_lut_sel held; i_lut_data is sampled at the end of the cycle.
  - If the sample ≠ shadow[k], o_error is set.
  - After address 15 → DONE.
- DONE: o_done = 1 for exactly one cycle, then IDLE.
  - o_error is valid while o_done is high.
  - o_error holds until the next accepted i_start or reset.
  - o_cfg_addr, o_cfg_data and o_lut_sel keep their last values in IDLE.
- Latency: counting the first cycle after the 16th-bit accept edge as cycle 1, o_done is high in cycle 16·(2+HOLD_CYCLES) + 32·VERIFY_EN + 1.
- Throughput: one bit per cycle in COLLECT when i_bit_valid is held high; 16 cycles minimum to collect.

Test Plan:
1. HOLD_CYCLES=2, VERIFY_EN=1, behavioural LUT attached; stream 0x8000 with valid held high → 16 enable pulses, each 2 cycles wide, at addresses 0..15; o_cfg_data = 1 only at address 15; o_done in cycle 97; o_error = 0; LUT then outputs 1 only for select 15.
2. Stream 0xA5C3 with i_bit_valid toggled every other cycle → only handshaken bits are stored; LUT truth table equals 0xA5C3; o_error = 0.
3. LUT model with config bit 3 stuck at 0; stream 0xFFFF → o_error = 1 when o_done pulses; o_error stays 1 in IDLE until the next i_start, then clears.
4. Assert i_rst during the PULSE of address 7 → all outputs are 0 the cycle after the edge (o_cfg_enable = 0, o_busy = 0); a following start with 0x0001 completes cleanly.
5. Pulse i_start during COLLECT → ignored, bit count unaffected; assert i_start and i_rst on the same edge → stays in IDLE, o_busy = 0.
6. VERIFY_EN=0, HOLD_CYCLES=2 → o_done in cycle 65; o_lut_sel stays 0; o_error = 0.
